// File: rtl/blast_mem_pkg.sv
// blast_mem_pkg
// Definitions shared by the BLAST buffer-memory arbiter and its clients:
//   - memory geometry (ADDR_W word address bits, DATA_W data bits)
//   - requester IDs used to index req/gnt/rvalid vectors
//   - base word addresses of the query, subject and hit regions
//   - rr_next(): round-robin pointer increment with wrap
package blast_mem_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 64;

  localparam int REQ_HOST    = 0;
  localparam int REQ_QUERY   = 1;
  localparam int REQ_SUBJECT = 2;
  localparam int REQ_HIT     = 3;

  localparam int QUERY_BASE   = 0;
  localparam int SUBJECT_BASE = 12;
  localparam int HIT_BASE     = 16262;

  // Index that follows idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/blast_rr_pick.sv
// blast_rr_pick
// Rotating-priority picker: returns the first set bit of req found by
// searching ptr, ptr+1, ... modulo N.
// Ports:
//   req    in  N     request vector
//   ptr    in  ID_W  index with highest priority this cycle
//   onehot out N     one-hot winner (all zero when no request)
//   valid  out 1     at least one request set
//   idx    out ID_W  binary index of the winner (0 when none)
module blast_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    int pos;
    onehot = '0;
    valid  = 1'b0;
    idx    = '0;
    pos    = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!valid && req[pos]) begin
        valid       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/blast_mem_arbiter.sv
// blast_mem_arbiter
// Sole driver of the single-port on-chip buffer memory. Four requesters
// (host, query loader, subject loader, hit writer) share the port through
// round-robin arbitration with burst locking; read data comes back tagged
// to the issuer READ_LATENCY cycles after the grant.
//
// Optional build macro BLAST_MEM_ARB_HOST_PRIO_EN: host (requester 0)
// pre-empts any burst in the same cycle, its beats are not burst-capped and
// its grants leave the round-robin pointer untouched.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   req/we/addr/wdata   per-requester beat request, direction, address, data
//   gnt                 one-hot beat grant
//   rvalid/rdata        one-hot read-return strobe, broadcast read data
//   mem_*               memory port (address/write/writedata/byteenable/
//                       chipselect out, readdata in)
//   owner_id            current owner (granted cycle) or last owner
//   busy                grant this cycle or a read in flight
//
// Handshake: a requester raises req[i] with we/addr/wdata valid and holds
// them unchanged until it sees gnt[i]; the beat is transferred in every
// cycle where req[i] & gnt[i]. gnt is combinational from req (no added
// latency) and never asserts without the matching req.
module blast_mem_arbiter
  import blast_mem_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  ADDR_W       = blast_mem_pkg::ADDR_W,
  parameter int  DATA_W       = blast_mem_pkg::DATA_W,
  parameter int  MAX_BURST    = 8,
  parameter int  READ_LATENCY = 2,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_address,
  output logic                      mem_write,
  output logic [DATA_W-1:0]         mem_writedata,
  output logic [DATA_W/8-1:0]       mem_byteenable,
  output logic                      mem_chipselect,
  input  logic [DATA_W-1:0]         mem_readdata,
  output logic [ID_W-1:0]           owner_id,
  output logic                      busy
);

  logic [ID_W-1:0] owner_q, owner_d;
  logic            locked_q, locked_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [READ_LATENCY-1:0]           pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0][ID_W-1:0] pipe_id_q, pipe_id_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;

  logic [NUM_REQ-1:0] rr_onehot;
  logic               rr_valid;
  logic [ID_W-1:0]    rr_idx;

  logic            cont;
  logic            host_win;
  logic            grant;
  logic [ID_W-1:0] win_idx;
  logic            push;

  blast_rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (rr_onehot),
    .valid  (rr_valid),
    .idx    (rr_idx)
  );

  // Winner selection: a locked owner below the burst cap keeps the port;
  // otherwise rotate from rr_ptr. Releasing req mid-burst falls straight
  // through to the rotating search in the same cycle.
  always_comb begin
    cont     = locked_q && req[owner_q] && (beat_cnt_q < 8'(MAX_BURST));
    host_win = 1'b0;
    grant    = rr_valid;
    win_idx  = rr_idx;
    if (cont) begin
      grant   = 1'b1;
      win_idx = owner_q;
    end
`ifdef BLAST_MEM_ARB_HOST_PRIO_EN
    // Host overrides any burst; it only counts as a continuation when it
    // already holds the lock, and is never capped.
    if (req[REQ_HOST]) begin
      host_win = 1'b1;
      grant    = 1'b1;
      win_idx  = ID_W'(REQ_HOST);
      cont     = locked_q && (owner_q == ID_W'(REQ_HOST));
    end
`endif
    if (reset) begin
      grant = 1'b0;
      cont  = 1'b0;
    end
  end

  // Memory port and requester-facing outputs.
  always_comb begin
    gnt = '0;
    if (grant) begin
      if (cont || host_win) gnt[win_idx] = 1'b1;
      else                  gnt = rr_onehot;
    end
    mem_chipselect = grant;
    mem_write      = grant && we[win_idx];
    mem_address    = grant ? addr[int'(win_idx)*ADDR_W +: ADDR_W] : addr_hold_q;
    mem_writedata  = grant ? wdata[int'(win_idx)*DATA_W +: DATA_W] : wdata_hold_q;
    mem_byteenable = '1;
    push           = grant && !we[win_idx];

    rvalid = '0;
    if (pipe_vld_q[READ_LATENCY-1] && !reset) rvalid[pipe_id_q[READ_LATENCY-1]] = 1'b1;
    rdata    = mem_readdata;
    owner_id = grant ? win_idx : owner_q;
    busy     = !reset && (grant || (|pipe_vld_q));
  end

  // Next-state for arbitration registers, read pipe and held port values.
  always_comb begin
    owner_d      = owner_q;
    locked_d     = locked_q;
    beat_cnt_d   = beat_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    addr_hold_d  = mem_address;
    wdata_hold_d = mem_writedata;
    pipe_vld_d   = '0;
    pipe_id_d    = '0;

    if (grant) begin
      if (cont) begin
        // Saturate: only an uncapped host burst can run this long.
        beat_cnt_d = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
      end else begin
        owner_d    = win_idx;
        locked_d   = 1'b1;
        beat_cnt_d = 8'd1;
        if (!host_win) rr_ptr_d = ID_W'(rr_next(int'(win_idx), NUM_REQ));
      end
    end else begin
      locked_d   = 1'b0;
      beat_cnt_d = 8'd0;
    end

    pipe_vld_d[0] = push;
    pipe_id_d[0]  = win_idx;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= '0;
      locked_q     <= 1'b0;
      beat_cnt_q   <= 8'd0;
      rr_ptr_q     <= '0;
      pipe_vld_q   <= '0;
      pipe_id_q    <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      owner_q      <= owner_d;
      locked_q     <= locked_d;
      beat_cnt_q   <= beat_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_id_q    <= pipe_id_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

endmodule

// File: tb/tb_blast_mem_arbiter.sv
// tb_blast_mem_arbiter
// Directed bench for blast_mem_arbiter: a cycle-by-cycle vector table from
// reset, then hand-written sequences for burst cap, reset with reads in
// flight, host arrival mid-burst, and round-robin order on a second
// instance built with MAX_BURST=1.
module tb_blast_mem_arbiter;
  import blast_mem_pkg::*;

  localparam int NR = 4;
  localparam int AW = blast_mem_pkg::ADDR_W;
  localparam int DW = blast_mem_pkg::DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NR-1:0]    req, we, req_rr;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata, mem_writedata, mem_readdata;
  logic [AW-1:0]    mem_address;
  logic             mem_write, mem_chipselect, busy;
  logic [DW/8-1:0]  mem_byteenable;
  logic [1:0]       owner_id;

  logic [NR-1:0]    gnt_rr, rvalid_rr;
  logic [DW-1:0]    rdata_rr, mem_writedata_rr;
  logic [AW-1:0]    mem_address_rr;
  logic             mem_write_rr, mem_chipselect_rr, busy_rr;
  logic [DW/8-1:0]  mem_byteenable_rr;
  logic [1:0]       owner_id_rr;

  blast_mem_arbiter #(.MAX_BURST(8), .READ_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_address(mem_address),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_readdata(mem_readdata), .owner_id(owner_id), .busy(busy)
  );

  blast_mem_arbiter #(.MAX_BURST(1), .READ_LATENCY(2)) dut_rr (
    .clk(clk), .reset(reset), .req(req_rr), .we(4'b0000), .addr(addr), .wdata(wdata),
    .gnt(gnt_rr), .rvalid(rvalid_rr), .rdata(rdata_rr), .mem_address(mem_address_rr),
    .mem_write(mem_write_rr), .mem_writedata(mem_writedata_rr),
    .mem_byteenable(mem_byteenable_rr), .mem_chipselect(mem_chipselect_rr),
    .mem_readdata(mem_readdata), .owner_id(owner_id_rr), .busy(busy_rr)
  );

  // ---------------- stimulus constants ----------------
  localparam logic [AW-1:0] A0 = 14'd40;
  localparam logic [AW-1:0] A1 = 14'(QUERY_BASE + 5);
  localparam logic [AW-1:0] A2 = 14'(SUBJECT_BASE + 3);
  localparam logic [AW-1:0] A3 = 14'(HIT_BASE + 1);
  localparam logic [DW-1:0] W0 = 64'h1111_0000_0000_0000;
  localparam logic [DW-1:0] W1 = 64'h2222_0000_0000_0001;
  localparam logic [DW-1:0] W2 = 64'h3333_0000_0000_0002;
  localparam logic [DW-1:0] W3 = 64'h4444_0000_0000_0003;
  localparam logic [DW-1:0] D0 = 64'hA5A5_0001;
  localparam logic [DW-1:0] D1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] D2 = 64'hFEDC_BA98_7654_3210;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_mis = 0;
  logic [NR-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_legal(input string nm);
    chk({nm, " gnt_onehot"}, 64'($onehot0(gnt)), 64'd1);
    chk({nm, " gnt_without_req"}, 64'(gnt & ~req), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] w, input logic [DW-1:0] rd);
    req          = r;
    we           = w;
    mem_readdata = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds req/we for n cycles and checks gnt against exp_q each cycle.
  task automatic run_seq(input string nm, input logic [NR-1:0] r, input logic [NR-1:0] w, input int n);
    logic [NR-1:0] e;
    for (int k = 0; k < n; k++) begin
      drive(r, w, '0);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk($sformatf("%s c%0d exp_q_empty", nm, k), 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s c%0d gnt", nm, k), 64'(gnt), 64'(e));
      end
      chk_legal($sformatf("%s c%0d", nm, k));
      next_cycle();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NR-1:0] req, we;
    logic [DW-1:0] rdin;
    logic [NR-1:0] gnt, rvalid;
    logic [DW-1:0] rdata;
    logic          wr, cs;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [1:0]    owner;
    logic          busy;
  } vec_t;

  function automatic vec_t mk(
    input logic [NR-1:0] r, input logic [NR-1:0] w, input logic [DW-1:0] rd,
    input logic [NR-1:0] g, input logic [NR-1:0] rv, input logic [DW-1:0] rdt,
    input logic wr, input logic cs, input logic [AW-1:0] ma, input logic [DW-1:0] mw,
    input logic [1:0] own, input logic bz);
    vec_t v;
    v.req = r; v.we = w; v.rdin = rd; v.gnt = g; v.rvalid = rv; v.rdata = rdt;
    v.wr = wr; v.cs = cs; v.maddr = ma; v.mwdata = mw; v.owner = own; v.busy = bz;
    return v;
  endfunction

  vec_t tbl[12];

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    logic [NR-1:0] seq_exp[13];

    // Single read, idle, write burst by hit writer, host takes over on release,
    // back-to-back host reads returning back-to-back.
    tbl[0]  = mk(4'b0010, 4'b0000, '0, 4'b0010, 4'b0000, '0, 1'b0, 1'b1, A1, '0, 2'd1, 1'b1);
    tbl[1]  = mk(4'b0000, 4'b0000, '0, 4'b0000, 4'b0000, '0, 1'b0, 1'b0, A1, '0, 2'd1, 1'b1);
    tbl[2]  = mk(4'b0000, 4'b0000, D0, 4'b0000, 4'b0010, D0, 1'b0, 1'b0, A1, '0, 2'd1, 1'b1);
    tbl[3]  = mk(4'b0000, 4'b0000, '0, 4'b0000, 4'b0000, '0, 1'b0, 1'b0, A1, '0, 2'd1, 1'b0);
    tbl[4]  = mk(4'b1000, 4'b1000, '0, 4'b1000, 4'b0000, '0, 1'b1, 1'b1, A3, W3, 2'd3, 1'b1);
    tbl[5]  = mk(4'b1000, 4'b1000, '0, 4'b1000, 4'b0000, '0, 1'b1, 1'b1, A3, W3, 2'd3, 1'b1);
    tbl[6]  = mk(4'b1000, 4'b1000, '0, 4'b1000, 4'b0000, '0, 1'b1, 1'b1, A3, W3, 2'd3, 1'b1);
    tbl[7]  = mk(4'b0001, 4'b0000, '0, 4'b0001, 4'b0000, '0, 1'b0, 1'b1, A0, '0, 2'd0, 1'b1);
    tbl[8]  = mk(4'b0001, 4'b0000, '0, 4'b0001, 4'b0000, '0, 1'b0, 1'b1, A0, '0, 2'd0, 1'b1);
    tbl[9]  = mk(4'b0000, 4'b0000, D1, 4'b0000, 4'b0001, D1, 1'b0, 1'b0, A0, '0, 2'd0, 1'b1);
    tbl[10] = mk(4'b0000, 4'b0000, D2, 4'b0000, 4'b0001, D2, 1'b0, 1'b0, A0, '0, 2'd0, 1'b1);
    tbl[11] = mk(4'b0000, 4'b0000, '0, 4'b0000, 4'b0000, '0, 1'b0, 1'b0, A0, '0, 2'd0, 1'b0);

    addr   = {A3, A2, A1, A0};
    wdata  = {W3, W2, W1, W0};
    req_rr = '0;
    reset  = 1'b1;
    drive(4'b1111, 4'b0000, '0);

    // Reset state: requests present but nothing granted.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset gnt", 64'(gnt), 64'd0);
    chk("reset chipselect", 64'(mem_chipselect), 64'd0);
    chk("reset write", 64'(mem_write), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset rvalid", 64'(rvalid), 64'd0);
    chk("byteenable", 64'(mem_byteenable), 64'hFF);
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].req, tbl[i].we, tbl[i].rdin);
      @(negedge clk);
      chk($sformatf("v%0d gnt", i), 64'(gnt), 64'(tbl[i].gnt));
      chk($sformatf("v%0d rvalid", i), 64'(rvalid), 64'(tbl[i].rvalid));
      chk($sformatf("v%0d mem_write", i), 64'(mem_write), 64'(tbl[i].wr));
      chk($sformatf("v%0d chipselect", i), 64'(mem_chipselect), 64'(tbl[i].cs));
      chk($sformatf("v%0d mem_address", i), 64'(mem_address), 64'(tbl[i].maddr));
      chk($sformatf("v%0d owner_id", i), 64'(owner_id), 64'(tbl[i].owner));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].busy));
      if (tbl[i].rvalid != '0) chk($sformatf("v%0d rdata", i), rdata, tbl[i].rdata);
      if (tbl[i].wr) chk($sformatf("v%0d writedata", i), mem_writedata, tbl[i].mwdata);
      chk_legal($sformatf("v%0d", i));
      next_cycle();
    end

    // Burst cap: subject alone for one beat, then subject+query held.
    // Expect 8 beats to subject, 8 to query, then subject again.
    for (int k = 0; k < 8; k++) exp_q.push_back(4'b0100);
    for (int k = 0; k < 8; k++) exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    run_seq("burst_start", 4'b0100, 4'b0100, 1);
    run_seq("burst_cap", 4'b0110, 4'b0110, 16);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    run_seq("burst_idle", 4'b0000, 4'b0000, 2);

    // Reset with two reads in flight: no rvalid may appear afterwards,
    // and the first grant is searched from pointer 0 again.
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    run_seq("rst_reads", 4'b0010, 4'b0000, 2);
    reset = 1'b1;
    drive(4'b0000, 4'b0000, '0);
    @(negedge clk);
    chk("rst_mid rvalid", 64'(rvalid), 64'd0);
    chk("rst_mid busy", 64'(busy), 64'd0);
    chk("rst_mid gnt", 64'(gnt), 64'd0);
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after c%0d rvalid", k), 64'(rvalid), 64'd0);
      chk($sformatf("rst_after c%0d busy", k), 64'(busy), 64'd0);
      next_cycle();
    end
    exp_q.push_back(4'b0001);
    run_seq("rst_ptr", 4'b1001, 4'b1001, 1);
    exp_q.push_back(4'b0000);
    run_seq("rst_idle", 4'b0000, 4'b0000, 1);

    // Host arrives in beat 3 of a subject burst, leaves after two cycles,
    // then query joins the subject.
`ifdef BLAST_MEM_ARB_HOST_PRIO_EN
    seq_exp = '{4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0100,
                4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                4'b0010};
`else
    seq_exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                4'b0010};
`endif
    for (int k = 0; k < 13; k++) exp_q.push_back(seq_exp[k]);
    run_seq("host_pre", 4'b0100, 4'b0100, 2);
    run_seq("host_in", 4'b0101, 4'b0101, 2);
    run_seq("host_out", 4'b0100, 4'b0100, 1);
    run_seq("host_after", 4'b0110, 4'b0110, 8);
    drive(4'b0000, 4'b0000, '0);
    next_cycle();

    // Round-robin order with MAX_BURST=1, all requesters held.
    req_rr = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      logic [NR-1:0] e;
`ifdef BLAST_MEM_ARB_HOST_PRIO_EN
      e = 4'b0001;
`else
      e = 4'(1 << (k % 4));
`endif
      @(negedge clk);
      chk($sformatf("rr c%0d gnt", k), 64'(gnt_rr), 64'(e));
      next_cycle();
    end
    req_rr = '0;
    next_cycle();

    if (exp_q.size() != 0) chk("exp_q leftover", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/blast_mem_arbiter.md
Name: blast_mem_arbiter

Overview:
- Arbitrates the single-port 64-bit on-chip buffer memory (14-bit word address) between four requesters: host/PCIe bridge, query loader, subject loader and hit-score writer.
- Round-robin arbitration with burst locking, so a streaming reader keeps the port for consecutive beats.
- Returns read data tagged to the issuing requester after a fixed memory latency.
- Sits between the BLAST sequencing logic and the memory port; it is the only driver of that port.

Parameters:
NUM_REQ, 4, number of requesters (ID 0 = host, 1 = query, 2 = subject, 3 = hit writer)
ADDR_W, 14, memory word address width
DATA_W, 64, memory data width
MAX_BURST, 8, maximum consecutive beats one owner may hold the port (1..255)
READ_LATENCY, 2, cycles from read issue to mem_readdata valid (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester beat request; held until granted
we  in  NUM_REQ  per-requester write (1) / read (0)
addr  in  NUM_REQ*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_REQ*DATA_W  per-requester write data
gnt  out  NUM_REQ  one-hot; beat accepted in any cycle where req[i]&gnt[i]
rvalid  out  NUM_REQ  one-hot read-return strobe
rdata  out  DATA_W  read data, broadcast; qualified by rvalid
mem_address  out  ADDR_W  memory address
mem_write  out  1  memory write strobe
mem_writedata  out  DATA_W  memory write data
mem_byteenable  out  DATA_W/8  all ones
mem_chipselect  out  1  high in any granted cycle
mem_readdata  in  DATA_W  memory read data
owner_id  out  2  current/last owner (debug)
busy  out  1  a grant is active this cycle or a read is in flight

Behaviour:
- State registers: owner, locked, beat_cnt (8b), rr_ptr, read pipe of READ_LATENCY entries {valid, id}.
- Reset values: owner=0, locked=0, beat_cnt=0, rr_ptr=0, pipe cleared. While reset is high, gnt=0, rvalid=0, mem_write=0, mem_chipselect=0, busy=0. A reset mid-burst drops in-flight reads and produces no rvalid.
- Winner selection is combinational, zero added latency:
  - Continuation: if locked && req[owner] && beat_cnt<MAX_BURST, winner=owner.
  - Otherwise the winner is the first set req[] searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - No req set: no grant.
- Memory drive:
  - Granted cycle: mem_address/mem_writedata from winner's slice; mem_write=we[winner]; chipselect=1.
  - Otherwise mem_write=0, chipselect=0, address/writedata hold last values.
- Register update on a grant:
  - Continuation: beat_cnt+=1.
  - New owner: owner<=winner, locked<=1, beat_cnt<=1, rr_ptr<=(winner+1) mod NUM_REQ.
- No grant: locked<=0, beat_cnt<=0.
- Burst cap: after MAX_BURST beats the owner loses lock priority. It wins again only if no other req is set, which restarts beat_cnt=1.
- Owner drops req mid-burst: same cycle re-arbitration from rr_ptr, no bubble.
- Reads:
  - A granted read pushes {1, winner} into the pipe.
  - rvalid[id] pulses exactly READ_LATENCY cycles later, with rdata=mem_readdata in that cycle.
  - Reads return in issue order. Back-to-back reads give back-to-back rvalid.
- Writes complete in the grant cycle; no response.
- Read-after-write to the same address is ordered by grant order; no hazard logic.
- At most one gnt bit is high per cycle. A gnt without req is illegal and must never occur.

Optional Feature:
- Macro: BLAST_MEM_ARB_HOST_PRIO_EN.
- Defined:
  - req[0] (host) pre-empts any burst in the same cycle; winner=0.
  - The pre-empted owner's lock is cleared.
  - Host beats are not capped by MAX_BURST.
  - rr_ptr is not updated by host grants.
- Undefined: host participates in plain round-robin like the other requesters.

Decomposition:
- Shared package blast_mem_pkg holds:
  - ADDR_W=14 and DATA_W=64.
  - Requester IDs REQ_HOST=0, REQ_QUERY=1, REQ_SUBJECT=2, REQ_HIT=3.
  - Region bases QUERY_BASE=0, SUBJECT_BASE=12, HIT_BASE=16262.
- One sub-module, blast_rr_pick: rotating-priority one-hot picker (req vector + rr_ptr in, one-hot + valid + index out).

Test Plan:
- Single read: req[1] alone, addr=5, READ_LATENCY=2 -> gnt[1] same cycle, mem_address=5, rvalid[1] exactly 2 cycles later with rdata=mem_readdata.
- Burst cap: req[2] and req[1] held continuously, owner 2 first -> 8 grants to 2, then 8 to 1, then 2 again; never two gnt bits high.
- Round-robin fairness: all four req held, MAX_BURST=1 -> grant order 0,1,2,3,0,... and rr_ptr wraps 3->0.
- Early release: owner 3 writes 3 beats then drops req while req[0] high -> gnt[0] in the next cycle with no idle cycle; mem_write=0 for host read.
- Reset mid-operation: reset asserted with 2 reads in flight -> no rvalid afterwards; after release, first grant is searched from rr_ptr=0.
- With BLAST_MEM_ARB_HOST_PRIO_EN: req[2] in beat 3 of its burst, req[0] rises -> gnt[0] that cycle, then 2 resumes with beat_cnt=1 once the host drops req.
